// File: rtl/nibble_serial_add_seq_pkg.sv
// Shared constants for the serial-nibble add/subtract sequencer.
// The add4 delay figures describe a typical TTL 4-bit adder for timed drop-in models.
package nibble_serial_add_seq_pkg;

  localparam int NIBW = 4;

  localparam int ADD4_TPD_SUM_NS   = 24;
  localparam int ADD4_TPD_CARRY_NS = 17;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/nibble_serial_add_seq_add4.sv
// Combinational 4-bit full adder, the single shared slice of the serial ALU.
module nibble_add4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       c0,
  output logic [3:0] sum,
  output logic       c4
);

  logic [4:0] total;

  assign total = {1'b0, a} + {1'b0, b} + {4'b0000, c0};
  assign sum   = total[3:0];
  assign c4    = total[4];

endmodule

// File: rtl/nibble_serial_add_seq.sv
// Add/subtract sequencer: one 4-bit adder reused NIB times, LS nibble first,
// with a registered carry between steps and results published on completion.
module nibble_serial_add_seq
  import nibble_serial_add_seq_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             start,
  input  logic             sub,
  input  logic             cin,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic [1:0]       state_dbg
);

  localparam int NIB = WIDTH / NIBW;
  localparam int KW  = $clog2(NIB);

  state_t             state, state_nx;
  logic [KW-1:0]      k;
  logic [KW+1:0]      base;
  logic               carry;
  logic [WIDTH-1:0]   opa, opb, res, res_nx;
  logic [NIBW-1:0]    nib_sum;
  logic               nib_c4;
  logic               last;

  assign base = {k, 2'b00};
  assign last = (k == KW'(NIB - 1));

  nibble_add4 u_add4 (
    .a   (opa[base +: NIBW]),
    .b   (opb[base +: NIBW]),
    .c0  (carry),
    .sum (nib_sum),
    .c4  (nib_c4)
  );

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) state <= ST_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: if (start) state_nx = ST_RUN;
      ST_RUN:  if (last)  state_nx = ST_DONE;
      ST_DONE: state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  // Result image including this step's nibble; on the last step it is the final sum.
  always_comb begin
    res_nx = res;
    res_nx[base +: NIBW] = nib_sum;
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      k     <= '0;
      carry <= 1'b0;
      opa   <= '0;
      opb   <= '0;
      res   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
    end else if (state == ST_IDLE && start) begin
      opa   <= a;
      opb   <= sub ? ~b : b;
      carry <= sub | cin;
      k     <= '0;
    end else if (state == ST_RUN) begin
      res   <= res_nx;
      carry <= nib_c4;
      if (last) begin
        k    <= '0;
        sum  <= res_nx;
        cout <= nib_c4;
        ovf  <= (opa[WIDTH-1] == opb[WIDTH-1]) && (res_nx[WIDTH-1] != opa[WIDTH-1]);
      end else begin
        k <= k + 1'b1;
      end
    end
  end

  assign busy      = (state != ST_IDLE);
  assign done      = (state == ST_DONE);
  assign state_dbg = state;

endmodule

// File: tb/tb_nibble_serial_add_seq.sv
// Self-checking bench for nibble_serial_add_seq (WIDTH=16): directed table,
// multi-cycle corner sequences and random operations against an arithmetic model.
module tb_nibble_serial_add_seq;

  localparam int W = 16;

  logic         clk, clr_n, start, sub, cin;
  logic [W-1:0] a, b, sum;
  logic         busy, done, cout, ovf;
  logic [1:0]   state_dbg;

  int n_vec = 0;
  int n_err = 0;

  nibble_serial_add_seq #(.WIDTH(W)) dut (
    .clk(clk), .clr_n(clr_n), .start(start), .sub(sub), .cin(cin),
    .a(a), .b(b), .busy(busy), .done(done), .sum(sum),
    .cout(cout), .ovf(ovf), .state_dbg(state_dbg)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    bit           sub;
    bit           cin;
    logic [W-1:0] exp_sum;
    bit           exp_cout;
    bit           exp_ovf;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference arithmetic: unsigned sum for result/carry, signed range for overflow.
  function automatic void ref_model(input logic [W-1:0] ra, input logic [W-1:0] rb,
                                    input bit rs, input bit rc,
                                    output logic [W-1:0] rsum, output bit rco, output bit rov);
    logic [W:0] full;
    int sa, sb, t;
    sa = int'($signed(ra));
    sb = int'($signed(rb));
    if (rs) begin
      full = {1'b0, ra} + {1'b0, ~rb} + 17'd1;
      t = sa - sb;
    end else begin
      full = {1'b0, ra} + {1'b0, rb} + {16'd0, rc};
      t = sa + sb + int'(rc);
    end
    rsum = full[W-1:0];
    rco  = full[W];
    rov  = (t > 32767) || (t < -32768);
  endfunction

  // Called just after a falling edge with the DUT idle; returns at the falling
  // edge of the first idle cycle after the done pulse.
  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_, input bit ts,
                        input bit tc, input logic [W-1:0] es, input bit ec, input bit eo,
                        input bit poke);
    logic [W-1:0] prev;
    int cyc;
    prev = sum;
    a = ta; b = tb_; sub = ts; cin = tc; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = W'($urandom); b = W'($urandom); sub = 1'($urandom); cin = 1'($urandom);
    cyc = 1;
    while (!done && cyc < 20) begin
      chk("busy_run", busy, 1);
      chk("sum_hold", sum, prev);
      if (poke) start = (cyc == 2);
      @(negedge clk);
      cyc++;
    end
    chk("done_latency", cyc, 5);
    chk("busy_done", busy, 1);
    chk("sum", sum, es);
    chk("cout", cout, ec);
    chk("ovf", ovf, eo);
    if (poke) start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_idle", busy, 0);
    chk("done_pulse", done, 0);
  endtask

  initial begin
    logic [W-1:0] ra, rb, es;
    bit rs, rc, ec, eo;

    vecs[0] = '{16'h1234, 16'h0FFF, 1'b0, 1'b0, 16'h2233, 1'b0, 1'b0};
    vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[2] = '{16'hFFFF, 16'h0001, 1'b0, 1'b1, 16'h0001, 1'b1, 1'b0};
    vecs[3] = '{16'h0005, 16'h0007, 1'b1, 1'b0, 16'hFFFE, 1'b0, 1'b0};
    vecs[4] = '{16'h8000, 16'h0001, 1'b1, 1'b0, 16'h7FFF, 1'b1, 1'b1};
    vecs[5] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};

    clr_n = 1'b0; start = 1'b0; sub = 1'b0; cin = 1'b0; a = '0; b = '0;
    #3;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_sum", sum, 0);
    chk("rst_cout", cout, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_state", state_dbg, 0);
    @(negedge clk);
    clr_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 6; i++)
      run_op(vecs[i].a, vecs[i].b, vecs[i].sub, vecs[i].cin,
             vecs[i].exp_sum, vecs[i].exp_cout, vecs[i].exp_ovf, 1'b0);

    // Starts during RUN and DONE are ignored; the back-to-back start is taken.
    run_op(16'h00F0, 16'h0F10, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b1);
    run_op(16'hA5A5, 16'h5A5A, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b0);

    // Asynchronous clear at step k=2 with a live carry in the chain.
    a = 16'hFFFF; b = 16'hFFFF; sub = 1'b0; cin = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2 clr_n = 1'b0;
    #1;
    chk("clr_busy", busy, 0);
    chk("clr_done", done, 0);
    chk("clr_sum", sum, 0);
    chk("clr_cout", cout, 0);
    chk("clr_ovf", ovf, 0);
    chk("clr_state", state_dbg, 0);
    @(negedge clk);
    clr_n = 1'b1;
    run_op(16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      rs = 1'($urandom_range(0, 1));
      rc = 1'($urandom_range(0, 1));
      if (i % 8 == 0) rb = 16'h8000;
      ref_model(ra, rb, rs, rc, es, ec, eo);
      run_op(ra, rb, rs, rc, es, ec, eo, 1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
